// File: rtl/alu_ctrl_pkg.sv
// Controller state encoding and arithmetic-unit phase enum.
// Shared by the sequential multiplier and divider datapaths.
package alu_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        PH_PREP = 2'b00,
        PH_ITER = 2'b01,
        PH_FIX  = 2'b10,
        PH_HOLD = 2'b11
    } phase_e;

endpackage

// File: rtl/divider_operation_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the result only if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pr_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] pr_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The partial remainder is always below the divisor, so whichever value
    // is kept fits back into WIDTH bits.
    always_comb begin
        shifted = {pr_i, bit_i};
        trial   = {1'b0, shifted} - {2'b00, dvs_i};
        q_o     = ~trial[WIDTH+1];
        pr_o    = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_operation.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock,
// sequenced by the shared IDLE/EXEC/DONE controller state bus.
module divider_operation
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       state,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             op_done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    phase_e           phase_q, phase_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             load_en, exec_en, zero_div, ovf_case;
    logic [WIDTH-1:0] step_pr;
    logic             step_q;

    assign load_en  = (state == ST_IDLE) || (state == ST_DONE);
    assign exec_en  = (state == ST_EXEC) && loaded_q;
    assign zero_div = (dvs_q == '0);
    assign ovf_case = sgn_q && (dvd_q == MOST_NEG) && (dvs_q == '1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_i  (pr_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .pr_o  (step_pr),
        .q_o   (step_q)
    );

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        phase_d = phase_q;
        if (load_en) begin
            phase_d = PH_PREP;
        end else if (exec_en) begin
            case (phase_q)
                PH_PREP: phase_d = (zero_div || ovf_case) ? PH_HOLD : PH_ITER;
                PH_ITER: if (cnt_q == CW'(WIDTH-1)) phase_d = PH_FIX;
                PH_FIX:  phase_d = PH_HOLD;
                default: phase_d = PH_HOLD;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        sgn_d    = sgn_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        pr_d     = pr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        q_d      = q_q;
        r_d      = r_q;
        done_d   = done_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        if (load_en) begin
            dvd_d    = dividend;
            dvs_d    = divisor;
            sgn_d    = signed_op;
            loaded_d = 1'b1;
            q_d      = '0;
            r_d      = '0;
            done_d   = 1'b0;
            dbz_d    = 1'b0;
            ovf_d    = 1'b0;
        end else if (exec_en) begin
            case (phase_q)
                PH_PREP: begin
                    q_neg_d = sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sgn_q && dvd_q[WIDTH-1];
                    dvd_d   = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                    dvs_d   = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    pr_d    = '0;
                    cnt_d   = '0;
                    if (zero_div) begin
                        q_d    = '1;
                        r_d    = dvd_q;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (ovf_case) begin
                        q_d    = MOST_NEG;
                        r_d    = '0;
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
                PH_ITER: begin
                    pr_d  = step_pr;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CW'(1);
                end
                PH_FIX: begin
                    q_d    = q_neg_q ? -dvd_q : dvd_q;
                    r_d    = r_neg_q ? -pr_q : pr_q;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= PH_PREP;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            sgn_q    <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            pr_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            sgn_q    <= sgn_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            pr_q     <= pr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            q_q      <= q_d;
            r_q      <= r_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign op_done     = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_operation.sv
// Self-checking bench for divider_operation: directed corner cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_divider_operation;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    localparam logic [1:0] S_RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  state = S_IDLE;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] Q, R;
    logic        op_done, div_by_zero, overflow;

    int tests = 0;
    int fails = 0;
    bit tb_done = 1'b0;

    divider_operation #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .Q           (Q),
        .R           (R),
        .op_done     (op_done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one division, from plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dbz, output logic ovf, output int lat);
        dbz = 1'b0;
        ovf = 1'b0;
        lat = 34;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; ovf = 1'b1; lat = 1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Expected outputs: edges counted in EXEC since the last operand load.
    logic [63:0] exp_qr;
    logic [2:0]  exp_flags;
    logic [31:0] m_q, m_r;
    logic        m_dbz, m_ovf, armed;
    int          m_lat, edges;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_qr = '0; exp_flags = '0; armed = 1'b0; edges = 0;
        end else if (state == S_IDLE || state == S_DONE) begin
            exp_qr = '0; exp_flags = '0;
            model(dividend, divisor, signed_op, m_q, m_r, m_dbz, m_ovf, m_lat);
            armed = 1'b1; edges = 0;
        end else if (state == S_EXEC && armed && edges < m_lat) begin
            edges++;
            if (edges == m_lat) begin
                exp_qr    = {m_q, m_r};
                exp_flags = {1'b1, m_dbz, m_ovf};
            end
        end
    end

    initial begin
        while (!tb_done) begin
            @(negedge clk);
            if (!tb_done) begin
                check("cycle_QR", {Q, R}, exp_qr);
                check("cycle_flags", {61'd0, op_done, div_by_zero, overflow}, {61'd0, exp_flags});
            end
        end
    end

    task automatic scramble();
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom);
    endtask

    // Load operands, enter EXEC and count edges until op_done (0 = timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        @(negedge clk);
        state = S_IDLE; dividend = a; divisor = b; signed_op = s;
        @(negedge clk);
        state = S_EXEC;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            scramble();
            @(negedge clk);
            if (op_done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, hi_cnt;
        logic [31:0] pq, pr;
        logic pd, po;
        int pl;

        model(32'd100, 32'd7, 1'b0, pq, pr, pd, po, pl);
        check("model_u100_7", {pq, pr}, {32'd14, 32'd2});
        model(32'hFFFF_FF9C, 32'd7, 1'b1, pq, pr, pd, po, pl);
        check("model_sm100_7", {pq, pr}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
        model(32'd100, 32'hFFFF_FFF9, 1'b1, pq, pr, pd, po, pl);
        check("model_s100_m7", {pq, pr}, {32'hFFFF_FFF2, 32'd2});

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_QR", {Q, R}, 64'd0);
        check("reset_flags", {61'd0, op_done, div_by_zero, overflow}, 64'd0);
        reset_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, lat);
        check("u100_7_lat", 64'(lat), 64'd34);
        check("u100_7_QR", {Q, R}, {32'd14, 32'd2});
        check("u100_7_flags", {61'd0, div_by_zero, overflow}, 64'd0);
        repeat (3) @(negedge clk);
        check("u100_7_held", {63'd0, op_done}, 64'd1);

        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
        check("sm100_7_QR", {Q, R}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, lat);
        check("s100_m7_QR", {Q, R}, {32'hFFFF_FFF2, 32'd2});

        run_op(32'h0000_1234, 32'd0, 1'b0, lat);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_QR", {Q, R}, {32'hFFFF_FFFF, 32'h0000_1234});
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        check("ovf_lat", 64'(lat), 64'd1);
        check("ovf_QR", {Q, R}, {32'h8000_0000, 32'd0});
        check("ovf_flag", {63'd0, overflow}, 64'd1);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        check("uns_min_lat", 64'(lat), 64'd34);
        check("uns_min_QR", {Q, R}, {32'd0, 32'h8000_0000});

        // Reset while a result is held must clear outputs without a clock edge.
        #2 reset_n = 1'b0;
        #1 check("async_reset_QR", {Q, R}, 64'd0);
        check("async_reset_done", {63'd0, op_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset at EXEC edge 10, EXEC held afterwards: nothing may complete.
        @(negedge clk);
        state = S_IDLE; dividend = 32'd500; divisor = 32'd3; signed_op = 1'b0;
        @(negedge clk);
        state = S_EXEC;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1 check("mid_reset_QR", {Q, R}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        hi_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (op_done) hi_cnt++;
        end
        check("post_reset_no_done", 64'(hi_cnt), 64'd0);

        // Abort to IDLE at edge 10, then a full recomputation.
        @(negedge clk);
        state = S_IDLE; dividend = 32'd77; divisor = 32'd5;
        @(negedge clk);
        state = S_EXEC;
        repeat (10) @(negedge clk);
        state = S_IDLE; dividend = 32'd1000; divisor = 32'd10; signed_op = 1'b0;
        @(negedge clk);
        check("abort_clear", {61'd0, op_done, div_by_zero, overflow}, 64'd0);
        state = S_EXEC;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            scramble();
            @(negedge clk);
            if (op_done) begin
                lat = n;
                break;
            end
        end
        check("abort_lat", 64'(lat), 64'd34);
        check("abort_QR", {Q, R}, {32'd100, 32'd0});

        // Randomized traffic with occasional reserved cycles and aborts.
        for (int t = 0; t < 120; t++) begin
            int k;
            @(negedge clk);
            state = ($urandom_range(1) == 0) ? S_IDLE : S_DONE;
            k = $urandom_range(9);
            signed_op = 1'($urandom);
            dividend  = $urandom;
            divisor   = $urandom;
            if (k == 0) divisor = 32'd0;
            else if (k == 1) begin dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; signed_op = 1'b1; end
            else if (k <= 4) divisor = $urandom_range(15, 1);
            else if (k == 5) divisor = -$urandom_range(15, 1);
            for (int c = 0; c < 38; c++) begin
                int r;
                @(negedge clk);
                r = $urandom_range(99);
                state = (r < 4) ? S_RSVD : (r < 6) ? S_IDLE : S_EXEC;
                scramble();
            end
        end

        @(negedge clk);
        tb_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divider_operation.md
# divider_operation

- Sequential signed/unsigned integer divider; the inverse arithmetic unit to the radix-4 multiplier datapath.
- Driven by the same top-level controller state bus (IDLE/EXEC/DONE).
- Produces quotient and remainder by radix-2 restoring division, one quotient bit per clock.
- Reports completion on `op_done`; flags divide-by-zero and signed overflow.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `state`  input  2  controller state: 2'b00 IDLE, 2'b01 EXEC, 2'b10 DONE, 2'b11 reserved.
- `signed_op`  input  1  1 = two's-complement division, 0 = unsigned; sampled with operands.
- `dividend`  input  WIDTH  numerator; sampled in IDLE/DONE.
- `divisor`  input  WIDTH  denominator; sampled in IDLE/DONE.
- `Q`  output  WIDTH  quotient, registered.
- `R`  output  WIDTH  remainder, registered.
- `op_done`  output  1  result valid; held high while `state` stays EXEC.
- `div_by_zero`  output  1  divisor was 0; valid with `op_done`.
- `overflow`  output  1  signed most-negative / -1; valid with `op_done`.

## Operation
- **Reset (async, `reset_n` low):**
  - `Q`, `R`, `op_done`, `div_by_zero`, `overflow` = 0.
  - Iteration counter = 0; internal `loaded` flag = 0.
- **IDLE or DONE:**
  - Clear all outputs to 0.
  - Latch `dividend`, `divisor`, `signed_op`; set `loaded` = 1; phase = PREP.
- **Reserved state 2'b11:** all registers hold; no X assignment.
- **EXEC with `loaded` = 0:** no activity; outputs hold 0.
- **EXEC, phase PREP (1 cycle):**
  - Capture sign of quotient (sign(dividend) XOR sign(divisor)) and sign of remainder (sign(dividend)); signs are 0 when unsigned.
  - Replace each operand with its magnitude; partial remainder = 0.
  - If divisor == 0: `Q` = all ones, `R` = dividend, `div_by_zero` = 1, `op_done` = 1, phase = HOLD.
  - Else if signed and dividend == 2^(WIDTH-1) and divisor == all ones: `Q` = 2^(WIDTH-1), `R` = 0, `overflow` = 1, `op_done` = 1, phase = HOLD.
  - Otherwise phase = ITER, counter = 0.
- **EXEC, phase ITER (WIDTH cycles):**
  - Each cycle: shift {partial remainder, dividend magnitude} left 1 bit.
  - Trial = upper half − divisor magnitude (WIDTH+1-bit subtract).
  - If trial is non-negative, the upper half takes the trial value and the new LSB = 1; otherwise the upper half is kept and the LSB = 0.
  - Counter increments; after count WIDTH-1, phase = FIX.
- **EXEC, phase FIX (1 cycle):**
  - `Q` = quotient magnitude, negated if the quotient sign is 1.
  - `R` = remainder magnitude, negated if the remainder sign is 1.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - `op_done` = 1; phase = HOLD.
- **EXEC, phase HOLD:** all outputs hold.
- **Abort:** leaving EXEC for IDLE/DONE mid-operation abandons the operation and reloads the operands the same cycle.

## Timing
- Edge count starts at the first rising edge sampled with `state` == EXEC.
- Normal case: `op_done` rises after rising edge WIDTH+2 (34 for WIDTH=32).
- `Q` and `R` update on that same edge.
- Divide-by-zero and overflow: `op_done` rises after edge 1.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Operands may change freely during EXEC; the values latched in the last IDLE/DONE cycle are used.
- Assertion of `reset_n` overrides every state immediately.
- After reset is released, a new IDLE/DONE cycle is required before EXEC has any effect.

## Structure
- Shared package `alu_ctrl_pkg`, also used by the multiplier:
  - State encoding constants IDLE/EXEC/DONE.
  - Phase enum PREP/ITER/FIX/HOLD.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- The top level holds the phase FSM, counter, sign capture and fix-up.

## Test plan
- Unsigned 100 / 7 → `Q` = 14, `R` = 2, `op_done` after edge 34, flags 0.
- Signed −100 / 7 → `Q` = 0xFFFF_FFF2, `R` = 0xFFFF_FFFE.
- Signed 100 / −7 → `Q` = 0xFFFF_FFF2, `R` = 2.
- Divisor 0, dividend 0x0000_1234 → `Q` = 0xFFFF_FFFF, `R` = 0x1234, `div_by_zero` = 1, `op_done` after edge 1.
- 0x8000_0000 / 0xFFFF_FFFF:
  - Signed → `Q` = 0x8000_0000, `R` = 0, `overflow` = 1, `op_done` after edge 1.
  - Unsigned → `Q` = 0, `R` = 0x8000_0000 after edge 34.
- Reset and abort:
  - `reset_n` pulsed low at EXEC edge 10 → all outputs 0 at once; EXEC held afterwards → `op_done` stays 0.
  - Separately, switching to IDLE at edge 10 → outputs clear; the next EXEC recomputes the full 34 edges.
